// File: rtl/qsn_layer_scheduler_if.sv
// Schedule stream and layer barrier between the QSN scheduler and the decoder datapath.
interface qsn_layer_scheduler_if #(
   parameter int unsigned ShiftWidth = 4,
   parameter int unsigned ColWidth   = 4
);
   logic                  sched_valid;
   logic                  sched_ready;
   logic [ShiftWidth-1:0] sched_shift;
   logic [ColWidth-1:0]   sched_col;
   logic                  sched_layer_last;
   logic                  sched_iter_last;
   logic                  layer_done;
   logic                  stop;

   modport master (
      output sched_valid, sched_shift, sched_col, sched_layer_last, sched_iter_last,
      input  sched_ready, layer_done, stop
   );

   modport slave (
      input  sched_valid, sched_shift, sched_col, sched_layer_last, sched_iter_last,
      output sched_ready, layer_done, stop
   );
endinterface

// File: rtl/qsn_layer_scheduler.sv
// Streams programmed base-matrix entries (column, shift, layer end) to the QSN datapath
// for N iterations, holding a barrier at each layer end with optional early termination.
module qsn_layer_scheduler #(
   parameter int unsigned LiftingFactor = 8,
   parameter int unsigned ShiftWidth    = $clog2(LiftingFactor) + 1,
   parameter int unsigned NumEntries    = 16,
   parameter int unsigned ColWidth      = 4,
   parameter int unsigned IterWidth     = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cfg_we,
   input  logic [$clog2(NumEntries)-1:0]   cfg_addr,
   input  logic [ColWidth-1:0]             cfg_col,
   input  logic [ShiftWidth-1:0]           cfg_shift,
   input  logic                            cfg_layer_last,
   output logic                            cfg_err,
   input  logic                            start,
   input  logic [$clog2(NumEntries):0]     num_entries,
   input  logic [IterWidth-1:0]            num_iter,
   qsn_layer_scheduler_if.master           sched,
   output logic                            busy,
   output logic                            done,
   output logic                            early
);
   localparam int unsigned AddrWidth = $clog2(NumEntries);
   localparam int unsigned CntWidth  = AddrWidth + 1;

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] RUN        = 2'd1;
   localparam logic [1:0] WAIT_LAYER = 2'd2;
   localparam logic [1:0] FIN        = 2'd3;

   typedef struct packed {
      logic [ColWidth-1:0]   col;
      logic [ShiftWidth-1:0] shift;
      logic                  layer_last;
   } entry_t;

   entry_t               r_table [NumEntries];

   logic [1:0]           r_state, w_state_nxt;
   logic [AddrWidth-1:0] r_e, w_e_nxt;
   logic [IterWidth-1:0] r_k, w_k_nxt;
   logic                 r_early, w_early_nxt;
   logic [CntWidth-1:0]  r_num_entries, w_n_eff;
   logic [IterWidth-1:0] r_num_iter, w_iter_eff;

   logic                  r_valid, r_layer_last, r_iter_last;
   logic [ShiftWidth-1:0] r_shift;
   logic [ColWidth-1:0]   r_col;
   logic                  r_busy, r_done, r_early_out, r_cfg_err;

   logic   w_hs, w_e_is_last, w_nxt_is_last, w_shift_ok;
   entry_t w_rd;

   assign w_hs          = r_valid && sched.sched_ready;
   assign w_e_is_last   = (CntWidth'(r_e) == r_num_entries - CntWidth'(1));
   assign w_shift_ok    = (cfg_shift < ShiftWidth'(LiftingFactor));
   // Run length comes straight from the inputs on the start cycle, from the latch afterwards.
   assign w_n_eff       = (r_state == IDLE) ? num_entries : r_num_entries;
   assign w_iter_eff    = (r_state == IDLE) ? num_iter : r_num_iter;
   assign w_rd          = r_table[w_e_nxt];
   assign w_nxt_is_last = (CntWidth'(w_e_nxt) == w_n_eff - CntWidth'(1));

   // Next-state and counter advance.
   always_comb begin
      w_state_nxt = r_state;
      w_e_nxt     = r_e;
      w_k_nxt     = r_k;
      w_early_nxt = r_early;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_e_nxt     = '0;
               w_k_nxt     = '0;
               w_early_nxt = 1'b0;
               w_state_nxt = (num_entries == '0 || num_iter == '0) ? FIN : RUN;
            end
         end
         RUN: begin
            if (w_hs) begin
               if (w_e_is_last) begin
                  w_e_nxt = '0;
                  w_k_nxt = r_k + IterWidth'(1);
               end else begin
                  w_e_nxt = r_e + AddrWidth'(1);
               end
               if (r_layer_last) w_state_nxt = WAIT_LAYER;
            end
         end
         WAIT_LAYER: begin
            if (sched.layer_done) begin
               if (sched.stop) begin
                  w_state_nxt = FIN;
                  w_early_nxt = 1'b1;
               end else if (r_k == r_num_iter) begin
                  w_state_nxt = FIN;
               end else begin
                  w_state_nxt = RUN;
               end
            end
         end
         FIN:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, counters and registered outputs; schedule fields are preloaded for the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_e           <= '0;
         r_k           <= '0;
         r_early       <= 1'b0;
         r_num_entries <= '0;
         r_num_iter    <= '0;
         r_valid       <= 1'b0;
         r_col         <= '0;
         r_shift       <= '0;
         r_layer_last  <= 1'b0;
         r_iter_last   <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_early_out   <= 1'b0;
         r_cfg_err     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_e     <= w_e_nxt;
         r_k     <= w_k_nxt;
         r_early <= w_early_nxt;
         if (r_state == IDLE && start) begin
            r_num_entries <= num_entries;
            r_num_iter    <= num_iter;
         end
         r_valid <= (w_state_nxt == RUN);
         if (w_state_nxt == RUN) begin
            r_col        <= w_rd.col;
            r_shift      <= w_rd.shift;
            r_layer_last <= w_rd.layer_last | w_nxt_is_last;
            r_iter_last  <= w_nxt_is_last && (w_k_nxt == w_iter_eff - IterWidth'(1));
         end else begin
            r_col        <= '0;
            r_shift      <= '0;
            r_layer_last <= 1'b0;
            r_iter_last  <= 1'b0;
         end
         r_busy      <= (w_state_nxt != IDLE);
         r_done      <= (r_state == FIN);
         r_early_out <= (r_state == FIN) && r_early;
         r_cfg_err   <= cfg_we && ((r_state != IDLE) || !w_shift_ok);
      end
   end

   // Table storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (!rst && cfg_we && r_state == IDLE && w_shift_ok)
         r_table[cfg_addr] <= entry_t'{col: cfg_col, shift: cfg_shift, layer_last: cfg_layer_last};
   end

   assign sched.sched_valid      = r_valid;
   assign sched.sched_col        = r_col;
   assign sched.sched_shift      = r_shift;
   assign sched.sched_layer_last = r_layer_last;
   assign sched.sched_iter_last  = r_iter_last;
   assign busy                   = r_busy;
   assign done                   = r_done;
   assign early                  = r_early_out;
   assign cfg_err                = r_cfg_err;
endmodule
